// File: rtl/tic_pkg.sv
// Shared types and defaults for the toggle interval capture block.
package tic_pkg;
  localparam int TIC_CNT_W = 8;
  localparam int TIC_DEPTH = 4;

  typedef enum logic {ARM, RUN} tic_state_e;

  typedef struct packed {
    logic                 level;
    logic [TIC_CNT_W-1:0] interval;
  } tic_rec_t;
endpackage

// File: rtl/tic_fifo.sv
// Synchronous record FIFO; pointers carry a wrap bit so full/empty fall out of
// the pointer difference. Head data reads as zero while empty.
module tic_fifo import tic_pkg::*; #(
  parameter int W     = 1 + TIC_CNT_W,
  parameter int DEPTH = TIC_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_wr, do_rd;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // a write into a full FIFO is only safe when the head leaves on the same edge
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/toggle_interval_capture.sv
// Level-change recorder: logs {new level, cycles old level was held} into a FIFO.
// Optional input synchronizer enabled by defining TOGGLE_INTERVAL_SYNC_EN.
module toggle_interval_capture import tic_pkg::*; #(
  parameter int CNT_W = TIC_CNT_W,
  parameter int DEPTH = TIC_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     d_in,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic                     rec_level,
  output logic [CNT_W-1:0]         rec_interval,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             level;
    logic [CNT_W-1:0] interval;
  } rec_t;

  tic_state_e       state, state_d;
  logic             d_s, det_ok;
  logic             d_q, dq_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             push, pop, drop, empty, full;
  rec_t             wr_rec, rd_rec;

`ifdef TOGGLE_INTERVAL_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] vld_pipe;

  // vld_pipe tracks how far real samples have propagated through the synchronizer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      vld_pipe <= '0;
    end else begin
      sync_q   <= {sync_q[0], d_in};
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end
  assign d_s    = sync_q[1];
  assign det_ok = vld_pipe[1];
`else
  assign d_s    = d_in;
  assign det_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ARM;
      d_q   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      d_q   <= dq_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    dq_d    = d_q;
    cnt_d   = cnt;
    push    = 1'b0;
    case (state)
      ARM: if (det_ok) begin
        state_d = RUN;
        dq_d    = d_s;
        cnt_d   = CNT_W'(1);
      end
      RUN: if (d_s != d_q) begin
        push  = 1'b1;
        dq_d  = d_s;
        cnt_d = CNT_W'(1);
      end else begin
        cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      end
      default: state_d = ARM;
    endcase
  end

  assign wr_rec = '{level: d_s, interval: cnt};
  assign pop    = rec_ready && !empty;
  assign drop   = push && full && !pop;

  tic_fifo #(.W(1 + CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (wr_rec),
    .rd_en   (pop),
    .rd_data (rd_rec),
    .count   (fifo_count),
    .empty   (empty),
    .full    (full)
  );

  // a drop in the same cycle as a clear must stay visible
  always_ff @(posedge clk) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  assign rec_valid    = !empty;
  assign rec_level    = rd_rec.level;
  assign rec_interval = rd_rec.interval;
endmodule

// File: tb/tb_toggle_interval_capture.sv
// Directed bench for toggle_interval_capture (CNT_W=4, DEPTH=4); both sync builds.
module tb_toggle_interval_capture;
  localparam int CNT_W = 4;
  localparam int DEPTH = 4;
`ifdef TOGGLE_INTERVAL_SYNC_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, d_in, rec_ready, clr_ovf;
  logic             rec_valid, rec_level, overflow;
  logic [CNT_W-1:0] rec_interval;
  logic [$clog2(DEPTH):0] fifo_count;

  int nchk = 0;
  int nbad = 0;

  toggle_interval_capture #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_in         (d_in),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_level    (rec_level),
    .rec_interval (rec_interval),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [13:0] seqv;
    logic        exp_v;
    rst_n = 1'b0; d_in = 1'b0; rec_ready = 1'b0; clr_ovf = 1'b0;

    // reset held with d_in toggling
    for (int i = 0; i < 3; i++) begin
      d_in = i[0];
      tick();
    end
    chk("rst_valid", rec_valid, 0);
    chk("rst_level", rec_level, 0);
    chk("rst_intv",  rec_interval, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf",   overflow, 0);

    // samples 0x3, 1x1, 0x5, then 1s; edge 1 is the ARM edge
    seqv = 14'b11111000001000;
    rst_n = 1'b1; rec_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      d_in = seqv[k-1];
      tick();
      exp_v = (k == 4 + SH) || (k == 5 + SH) || (k == 10 + SH);
      chk($sformatf("iv_valid_e%0d", k), rec_valid, int'(exp_v));
      if (k == 4 + SH) begin
        chk("iv_rec0_lvl", rec_level, 1); chk("iv_rec0_int", rec_interval, 3);
      end
      if (k == 5 + SH) begin
        chk("iv_rec1_lvl", rec_level, 0); chk("iv_rec1_int", rec_interval, 1);
      end
      if (k == 10 + SH) begin
        chk("iv_rec2_lvl", rec_level, 1); chk("iv_rec2_int", rec_interval, 5);
      end
    end

    // saturation: hold 1 for 40 samples, then drop to 0
    rst_n = 1'b0; rec_ready = 1'b0; tick();
    rst_n = 1'b1; d_in = 1'b1;
    repeat (40) tick();
    d_in = 1'b0; tick();
    repeat (SH) tick();
    chk("sat_count", fifo_count, 1);
    chk("sat_level", rec_level, 0);
    chk("sat_intv",  rec_interval, 15);

    // overflow: 6 records into a 4-deep FIFO
    rst_n = 1'b0; d_in = 1'b0; tick();
    rst_n = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      d_in = ~d_in;
      tick();
    end
    repeat (SH) tick();
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag",  overflow, 1);
    chk("ovf_head_lvl", rec_level, 1);
    chk("ovf_head_int", rec_interval, 3);

    // clear coinciding with another drop: set wins
    d_in = 1'b1;
    repeat (SH) tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_setwins", overflow, 1);
    chk("ovf_count2",  fifo_count, 4);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    // full FIFO with pop and push on the same edge
    d_in = 1'b0;
    repeat (SH) tick();
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    chk("pp_count", fifo_count, 4);
    chk("pp_ovf",   overflow, 0);
    chk("pp_h0_lvl", rec_level, 0); chk("pp_h0_int", rec_interval, 1);
    rec_ready = 1'b1;
    tick();
    chk("pp_h1_lvl", rec_level, 1); chk("pp_h1_int", rec_interval, 1);
    tick();
    chk("pp_h2_lvl", rec_level, 0); chk("pp_h2_int", rec_interval, 1);
    tick();
    chk("pp_tail_lvl", rec_level, 0); chk("pp_tail_int", rec_interval, 2 + SH);
    tick();
    chk("drain_valid", rec_valid, 0);
    chk("drain_count", fifo_count, 0);
    tick();
    chk("empty_pop_count", fifo_count, 0);
    chk("empty_intv", rec_interval, 0);
    rec_ready = 1'b0;

    // reset with 3 records stored
    d_in = 1'b1; tick();
    d_in = 1'b0; tick();
    d_in = 1'b1; tick();
    repeat (SH) tick();
    chk("mid_count", fifo_count, 3);
    rst_n = 1'b0; tick();
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_valid", rec_valid, 0);
    chk("mid_rst_ovf",   overflow, 0);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
